// File: rtl/qam_demod_mix.sv
// ----------------------------------------------------------------------------
// qam_demod_mix
//
// Quadrature down-mixer and symbol integrator for a received QAM stream.
// Each accepted sample is multiplied by the local carrier (cos for I, -sin
// for Q); the products are summed over SAMPLES_PER_SYM samples and the top
// OUT_WIDTH bits of each sum are presented as the recovered symbol value.
// Symbol framing starts on the carrier phase-zero flag and then runs
// back-to-back until the sample stream stops.
//
// Pipeline (E = clock edge that accepts the last sample of a symbol):
//   E   : products registered            (stage 1)
//   E+1 : final sums in the accumulators (stage 2)
//   E+2 : i_data / q_data / iq_valid     (output stage)
//
// Ports
//   axi_clk    in   1              clock, rising edge
//   axi_rstn   in   1              asynchronous active-low reset
//   qam_valid  in   1              qam_data valid this cycle
//   qam_data   in   QAM_WIDTH      signed received sample
//   cor_cos    in   CARRIER_WIDTH  signed local cosine, 1Q6
//   cor_sin    in   CARRIER_WIDTH  signed local sine, 1Q6
//   cor_zero   in   1              carrier phase-zero flag
//   i_data     out  OUT_WIDTH      recovered in-phase value (held)
//   q_data     out  OUT_WIDTH      recovered quadrature value (held)
//   iq_valid   out  1              one-cycle strobe qualifying i_data/q_data
//   sync_err   out  1              one-cycle strobe, symbol aborted mid-way
//
// Build option
//   QAM_DEMOD_ROUND_EN  defined   : round-half-up with positive saturation
//                       undefined : plain truncation (floor)
// ----------------------------------------------------------------------------
module qam_demod_mix #(
    parameter int QAM_WIDTH       = 12,
    parameter int CARRIER_WIDTH   = 8,
    parameter int SAMPLES_PER_SYM = 8,
    parameter int OUT_WIDTH       = 10
) (
    input  logic                     axi_clk,
    input  logic                     axi_rstn,
    input  logic                     qam_valid,
    input  logic [QAM_WIDTH-1:0]     qam_data,
    input  logic [CARRIER_WIDTH-1:0] cor_cos,
    input  logic [CARRIER_WIDTH-1:0] cor_sin,
    input  logic                     cor_zero,
    output logic [OUT_WIDTH-1:0]     i_data,
    output logic [OUT_WIDTH-1:0]     q_data,
    output logic                     iq_valid,
    output logic                     sync_err
);

    localparam int PROD_W   = QAM_WIDTH + CARRIER_WIDTH + 1;
    localparam int SYM_LOG2 = $clog2(SAMPLES_PER_SYM);
    localparam int ACC_W    = PROD_W + SYM_LOG2;
    localparam int CNT_W    = SYM_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_SYM - 1);

`ifdef QAM_DEMOD_ROUND_EN
    // One extra bit below the output LSB is needed to decide rounding.
    localparam int CONV_W = OUT_WIDTH + 1;
`else
    localparam int CONV_W = OUT_WIDTH;
`endif

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ZERO = 2'd1,
        ST_ACCUM     = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Output conversion: top bits of the accumulator to OUT_WIDTH.
    // In the rounding build the input carries one extra bit (the half-LSB);
    // the sum is formed one bit wider so an overflow can only appear as a
    // positive wrap, which is clamped to the largest positive value.
    // ------------------------------------------------------------------------
    function automatic logic [OUT_WIDTH-1:0] to_out(input logic [CONV_W-1:0] top);
`ifdef QAM_DEMOD_ROUND_EN
        logic [OUT_WIDTH:0] wide;
        wide = {top[CONV_W-1], top[CONV_W-1:1]} + {{OUT_WIDTH{1'b0}}, top[0]};
        if (wide[OUT_WIDTH] != wide[OUT_WIDTH-1]) begin
            to_out = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else begin
            to_out = wide[OUT_WIDTH-1:0];
        end
`else
        to_out = top;
`endif
    endfunction

    // Sign-extend a product to accumulator width.
    function automatic logic [ACC_W-1:0] ext_prod(input logic [PROD_W-1:0] p);
        ext_prod = {{SYM_LOG2{p[PROD_W-1]}}, p};
    endfunction

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               accept_s;
    logic               abort_s;
    logic               first_s;
    logic               last_s;

    logic signed [CARRIER_WIDTH:0] cos_ext_s;
    logic signed [CARRIER_WIDTH:0] sin_ext_s;
    logic signed [CARRIER_WIDTH:0] neg_sin_s;
    logic signed [PROD_W-1:0]      qam_w_s;
    logic signed [PROD_W-1:0]      cos_w_s;
    logic signed [PROD_W-1:0]      nsin_w_s;
    logic signed [PROD_W-1:0]      pi_s;
    logic signed [PROD_W-1:0]      pq_s;

    logic [PROD_W-1:0]  pi_r;
    logic [PROD_W-1:0]  pq_r;
    logic               p_vld_r;
    logic               p_first_r;
    logic               p_last_r;

    logic [ACC_W-1:0]   acc_i_r;
    logic [ACC_W-1:0]   acc_q_r;
    logic               dump_r;

    // ------------------------------------------------------------------------
    // Mixer arithmetic. The sine is negated in CARRIER_WIDTH+1 bits so that
    // -(-2^(CARRIER_WIDTH-1)) is representable; operands are widened to the
    // product width so the signed multiply cannot overflow.
    // ------------------------------------------------------------------------
    assign cos_ext_s = $signed({cor_cos[CARRIER_WIDTH-1], cor_cos});
    assign sin_ext_s = $signed({cor_sin[CARRIER_WIDTH-1], cor_sin});
    assign neg_sin_s = -sin_ext_s;

    assign qam_w_s  = $signed({{(PROD_W-QAM_WIDTH){qam_data[QAM_WIDTH-1]}}, qam_data});
    assign cos_w_s  = $signed({{(PROD_W-CARRIER_WIDTH-1){cos_ext_s[CARRIER_WIDTH]}}, cos_ext_s});
    assign nsin_w_s = $signed({{(PROD_W-CARRIER_WIDTH-1){neg_sin_s[CARRIER_WIDTH]}}, neg_sin_s});

    assign pi_s = qam_w_s * cos_w_s;
    assign pq_s = qam_w_s * nsin_w_s;

    assign first_s = (cnt_r == {CNT_W{1'b0}});
    assign last_s  = (cnt_r == CNT_LAST);

    // Framing FSM: next state, sample acceptance and abort detection.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (qam_valid) begin
                    state_nxt_s = ST_WAIT_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_ZERO: begin
                if (!qam_valid) begin
                    state_nxt_s = ST_IDLE;
                end else if (cor_zero) begin
                    // Phase-zero sample is sample 0 of the first symbol.
                    state_nxt_s = ST_ACCUM;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_ZERO;
                end
            end
            ST_ACCUM: begin
                if (qam_valid) begin
                    state_nxt_s = ST_ACCUM;
                    accept_s    = 1'b1;
                end else begin
                    // Stopping on a symbol boundary is a clean end.
                    state_nxt_s = ST_IDLE;
                    abort_s     = !first_s;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sample counter next value: wraps per symbol, cleared on leaving ACCUM.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (accept_s) begin
            if (last_s) begin
                cnt_nxt_s = {CNT_W{1'b0}};
            end else begin
                cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (state_nxt_s == ST_IDLE) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // FSM state and sample counter registers.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Stage 1: register products with their symbol-position tags.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            pi_r      <= {PROD_W{1'b0}};
            pq_r      <= {PROD_W{1'b0}};
            p_vld_r   <= 1'b0;
            p_first_r <= 1'b0;
            p_last_r  <= 1'b0;
        end else if (abort_s) begin
            // The in-flight product belongs to the aborted symbol.
            pi_r      <= {PROD_W{1'b0}};
            pq_r      <= {PROD_W{1'b0}};
            p_vld_r   <= 1'b0;
            p_first_r <= 1'b0;
            p_last_r  <= 1'b0;
        end else begin
            p_vld_r   <= accept_s;
            p_first_r <= accept_s && first_s;
            p_last_r  <= accept_s && last_s;
            if (accept_s) begin
                pi_r <= pi_s;
                pq_r <= pq_s;
            end else begin
                pi_r <= pi_r;
                pq_r <= pq_r;
            end
        end
    end

    // Stage 2: accumulate; first sample of a symbol loads instead of adding.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            acc_i_r <= {ACC_W{1'b0}};
            acc_q_r <= {ACC_W{1'b0}};
            dump_r  <= 1'b0;
        end else if (abort_s) begin
            acc_i_r <= {ACC_W{1'b0}};
            acc_q_r <= {ACC_W{1'b0}};
            dump_r  <= 1'b0;
        end else if (p_vld_r) begin
            if (p_first_r) begin
                acc_i_r <= ext_prod(pi_r);
                acc_q_r <= ext_prod(pq_r);
            end else begin
                acc_i_r <= acc_i_r + ext_prod(pi_r);
                acc_q_r <= acc_q_r + ext_prod(pq_r);
            end
            dump_r <= p_last_r;
        end else begin
            dump_r <= 1'b0;
        end
    end

    // Output stage: capture completed sums and emit the strobes. A dump in
    // flight at an abort belongs to the previous, complete symbol.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            i_data   <= {OUT_WIDTH{1'b0}};
            q_data   <= {OUT_WIDTH{1'b0}};
            iq_valid <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            iq_valid <= dump_r;
            sync_err <= abort_s;
            if (dump_r) begin
                i_data <= to_out(acc_i_r[ACC_W-1 -: CONV_W]);
                q_data <= to_out(acc_q_r[ACC_W-1 -: CONV_W]);
            end else begin
                i_data <= i_data;
                q_data <= q_data;
            end
        end
    end

endmodule

// File: tb/tb_qam_demod_mix.sv
// ----------------------------------------------------------------------------
// tb_qam_demod_mix
//
// Directed bench for qam_demod_mix with hand-computed expectations
// (defaults: 12-bit samples, 1Q6 carrier, 8 samples/symbol, output acc[23:14]).
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// ----------------------------------------------------------------------------
module tb_qam_demod_mix;

    localparam int QW  = 12;
    localparam int CW  = 8;
    localparam int SPS = 8;
    localparam int OW  = 10;

    logic          axi_clk;
    logic          axi_rstn;
    logic          qam_valid;
    logic [QW-1:0] qam_data;
    logic [CW-1:0] cor_cos;
    logic [CW-1:0] cor_sin;
    logic          cor_zero;
    logic [OW-1:0] i_data;
    logic [OW-1:0] q_data;
    logic          iq_valid;
    logic          sync_err;

    int total;
    int bad;

    qam_demod_mix #(
        .QAM_WIDTH       (QW),
        .CARRIER_WIDTH   (CW),
        .SAMPLES_PER_SYM (SPS),
        .OUT_WIDTH       (OW)
    ) dut (
        .axi_clk   (axi_clk),
        .axi_rstn  (axi_rstn),
        .qam_valid (qam_valid),
        .qam_data  (qam_data),
        .cor_cos   (cor_cos),
        .cor_sin   (cor_sin),
        .cor_zero  (cor_zero),
        .i_data    (i_data),
        .q_data    (q_data),
        .iq_valid  (iq_valid),
        .sync_err  (sync_err)
    );

    // Free-running clock, period 10.
    initial begin
        axi_clk = 1'b0;
        forever #5 axi_clk = ~axi_clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        total = total + 1;
        if (got != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic cz, input int d, input int c, input int s);
        qam_valid = v;
        cor_zero  = cz;
        qam_data  = QW'(d);
        cor_cos   = CW'(c);
        cor_sin   = CW'(s);
    endtask

    // From IDLE: one valid cycle to reach WAIT_ZERO, then one full symbol
    // starting on cor_zero, then check the strobe lands two edges later.
    task automatic run_symbol(input string tag, input int d, input int c, input int s,
                              input int ei, input int eq);
        drive(1'b1, 1'b0, d, c, s);
        step();
        for (int k = 0; k < SPS; k++) begin
            drive(1'b1, (k == 0), d, c, s);
            step();
        end
        drive(1'b0, 1'b0, d, c, s);
        step();
        check({tag, "_early_iq"}, int'(iq_valid), 0);
        check({tag, "_no_sync"}, int'(sync_err), 0);
        step();
        check({tag, "_iq"}, int'(iq_valid), 1);
        check({tag, "_i"}, int'($signed(i_data)), ei);
        check({tag, "_q"}, int'($signed(q_data)), eq);
        step();
        check({tag, "_iq_pulse"}, int'(iq_valid), 0);
        check({tag, "_i_hold"}, int'($signed(i_data)), ei);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        axi_rstn = 1'b0;
        drive(1'b0, 1'b0, 0, 0, 0);
        step();
        step();
        check("rst_i", int'(i_data), 0);
        check("rst_q", int'(q_data), 0);
        check("rst_iq", int'(iq_valid), 0);
        check("rst_sync", int'(sync_err), 0);
        axi_rstn = 1'b1;
        step();

        // 256*64*8 = 2^17 -> 8 in both builds.
        run_symbol("dc_i", 256, 64, 0, 8, 0);

        // 16*64*8 = 2^13 = exactly half an output LSB.
`ifdef QAM_DEMOD_ROUND_EN
        run_symbol("half_lsb", 16, 64, 0, 1, 0);
`else
        run_symbol("half_lsb", 16, 64, 0, 0, 0);
`endif

        // Ten cycles without cor_zero: nothing may be counted.
        // I: 100*64*8 = 51200 -> 3; Q: -100*32*8 = -25600 -> -2 (both builds).
        drive(1'b1, 1'b0, 100, 64, 32);
        for (int k = 0; k < 10; k++) begin
            step();
            check("wz_no_iq", int'(iq_valid), 0);
        end
        for (int k = 0; k < SPS; k++) begin
            drive(1'b1, (k == 0), 100, 64, 32);
            step();
            check("wz_acc_no_iq", int'(iq_valid), 0);
        end
        drive(1'b0, 1'b0, 100, 64, 32);
        step();
        check("wz_lat1", int'(iq_valid), 0);
        step();
        check("wz_iq", int'(iq_valid), 1);
        check("wz_i", int'($signed(i_data)), 3);
        check("wz_q", int'($signed(q_data)), -2);

        // 16 back-to-back samples: strobes after steps 9 and 17, 8 apart.
        drive(1'b1, 1'b0, 256, 0, 64);
        step();
        for (int s = 0; s < 18; s++) begin
            drive((s < 16), (s == 0), 256, 0, 64);
            step();
            check("b2b_iq", int'(iq_valid), ((s == 9) || (s == 17)) ? 1 : 0);
            if ((s == 9) || (s == 17)) begin
                check("b2b_q", int'($signed(q_data)), -8);
                check("b2b_i", int'($signed(i_data)), 0);
            end
        end

        // Abort after 5 samples.
        drive(1'b1, 1'b0, 256, 64, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, (k == 0), 256, 64, 0);
            step();
        end
        drive(1'b0, 1'b0, 256, 64, 0);
        step();
        check("abort_sync", int'(sync_err), 1);
        check("abort_iq", int'(iq_valid), 0);
        step();
        check("abort_sync_pulse", int'(sync_err), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("abort_no_iq", int'(iq_valid), 0);
        end
        check("abort_q_hold", int'($signed(q_data)), -8);
        run_symbol("after_abort", 256, 64, 0, 8, 0);

        // Reset in the middle of a symbol, checked between clock edges.
        drive(1'b1, 1'b0, 256, 0, 64);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, (k == 0), 256, 0, 64);
            step();
        end
        #2;
        axi_rstn = 1'b0;
        #1;
        check("async_rst_i", int'(i_data), 0);
        check("async_rst_q", int'(q_data), 0);
        check("async_rst_iq", int'(iq_valid), 0);
        check("async_rst_sync", int'(sync_err), 0);
        step();
        axi_rstn = 1'b1;
        drive(1'b1, 1'b0, 256, 0, 64);
        for (int k = 0; k < 12; k++) begin
            step();
            check("post_rst_no_iq", int'(iq_valid), 0);
        end
        check("post_rst_no_sync", int'(sync_err), 0);
        drive(1'b0, 1'b0, 256, 0, 64);
        step();
        run_symbol("post_rst", 256, 0, 64, 0, -8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qam_demod_mix.md
QAM_DEMOD_MIX -- requirements
Module: qam_demod_mix

Interface
REQ-001 Parameter QAM_WIDTH, 12, signed width of the received QAM sample.
REQ-002 Parameter CARRIER_WIDTH, 8, signed width of the local carrier, format 1Q6.
REQ-003 Parameter SAMPLES_PER_SYM, 8, samples per symbol; a power of two, at least 2.
REQ-004 Parameter OUT_WIDTH, 10, signed width of the I and Q outputs.
REQ-005 axi_clk  in  1  single clock; all logic on its rising edge.
REQ-006 axi_rstn  in  1  reset, asynchronous, active-low.
REQ-007 qam_valid  in  1  qam_data is valid this cycle.
REQ-008 qam_data  in  QAM_WIDTH  signed received sample.
REQ-009 cor_cos  in  CARRIER_WIDTH  signed local cosine.
REQ-010 cor_sin  in  CARRIER_WIDTH  signed local sine.
REQ-011 cor_zero  in  1  carrier phase-zero flag.
REQ-012 i_data  out  OUT_WIDTH  recovered in-phase symbol value.
REQ-013 q_data  out  OUT_WIDTH  recovered quadrature symbol value.
REQ-014 iq_valid  out  1  one-cycle strobe qualifying i_data and q_data.
REQ-015 sync_err  out  1  one-cycle strobe: symbol aborted mid-accumulation.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_ZERO and ACCUM, plus a sample counter 0..SAMPLES_PER_SYM-1.
REQ-017 Transitions SHALL be: IDLE->WAIT_ZERO on qam_valid=1; WAIT_ZERO->IDLE on qam_valid=0; WAIT_ZERO->ACCUM on qam_valid=1 with cor_zero=1.
REQ-018 A sample SHALL be accepted when qam_valid=1 and either the state is ACCUM, or the state is WAIT_ZERO with cor_zero=1; the latter case is sample 0 of the first symbol.
REQ-019 Each accepted sample SHALL increment the counter; the counter SHALL wrap to 0 after SAMPLES_PER_SYM-1, continuing back-to-back symbols with no gap.
REQ-020 Pipeline stage 1 SHALL register the products pi=qam_data*cor_cos and pq=qam_data*(-cor_sin).
REQ-021 The negation in REQ-020 SHALL be computed in CARRIER_WIDTH+1 bits, and the products SHALL be QAM_WIDTH+CARRIER_WIDTH+1 bits signed, with no overflow.
REQ-022 Stage 2 SHALL hold accumulators of product width plus log2(SAMPLES_PER_SYM) bits; the first sample of each symbol SHALL load the accumulator and later samples SHALL add to it.
REQ-023 On the stage-2 update of the last sample of a symbol, i_data and q_data SHALL register the top OUT_WIDTH bits of the final sums and iq_valid SHALL pulse high; latency is 2 cycles from the acceptance edge of the last sample.
REQ-024 qam_valid=0 in ACCUM with counter=0 SHALL return the FSM to IDLE without sync_err, and any in-flight dump SHALL still complete.
REQ-025 qam_valid=0 in ACCUM with counter!=0 SHALL return the FSM to IDLE, clear the counter, discard the partial sums and in-flight products, produce no iq_valid for that symbol, and pulse sync_err for one cycle.
REQ-026 cor_zero SHALL be ignored in ACCUM.
REQ-027 i_data and q_data SHALL hold their values between iq_valid strobes.

Reset
REQ-028 axi_rstn=0 SHALL immediately force the following, including mid-symbol: state IDLE, counter 0, products 0, accumulators 0, i_data 0, q_data 0, iq_valid 0, sync_err 0.
REQ-029 After axi_rstn rises, the first accepted sample SHALL require a new cor_zero.

Configuration
REQ-030 The macro QAM_DEMOD_ROUND_EN SHALL select the output conversion.
REQ-031 With QAM_DEMOD_ROUND_EN defined, the output SHALL be round-half-up: add half an output LSB before truncation, computed one bit wider, and saturate to the maximum positive value on overflow.
REQ-032 Without QAM_DEMOD_ROUND_EN, the output SHALL be plain truncation (floor) with no extra logic.

Verification (defaults: QAM_WIDTH 12, CARRIER_WIDTH 8, SAMPLES_PER_SYM 8, OUT_WIDTH 10; output = acc[23:14])
REQ-033 qam_data=256, cos=64, sin=0, cor_zero at the first sample, 8 samples -> i_data=8, q_data=0, iq_valid 2 cycles after the 8th sample, both build options.
REQ-034 qam_data=256, cos=0, sin=64, 16 back-to-back samples -> two iq_valid strobes exactly 8 cycles apart, each with q_data=-8 and i_data=0.
REQ-035 qam_data=16, cos=64, sin=0, 8 samples -> i_data=0 without the macro, i_data=1 with QAM_DEMOD_ROUND_EN.
REQ-036 qam_valid high for 10 cycles with cor_zero=0, then cor_zero=1 -> no accumulation before cor_zero, and iq_valid fires 2 cycles after the 8th sample counted from the cor_zero cycle.
REQ-037 qam_valid drops after 5 samples -> sync_err pulses for one cycle, no iq_valid, FSM in IDLE; a following clean symbol gives the correct value.
REQ-038 axi_rstn asserted mid-ACCUM -> all outputs 0 without waiting for a clock edge; no stale iq_valid after release.
